// File: rtl/asi_pkg.sv
// Shared 8b/10b constants and table helpers for the ASI output path.
// Tables return the RD- form; the encoder derives the RD+ form by complementing.
package asi_pkg;

    localparam logic [7:0] IDLE_DEFAULT = 8'hBC;
    localparam logic [7:0] K28_5_BYTE   = 8'hBC;
    localparam logic [9:0] K28_5_RDN    = 10'b001111_1010;
    localparam logic [9:0] K28_5_RDP    = 10'b110000_0101;

    typedef enum logic [2:0] {PH0, PH1, PH2, PH3, PH4} phase_t;

    function automatic logic is_legal_k(input logic [7:0] b);
        return (b[4:0] == 5'd28) || (b == 8'hF7) || (b == 8'hFB) ||
               (b == 8'hFD) || (b == 8'hFE);
    endfunction

    function automatic logic [2:0] ones_cnt(input logic [5:0] v);
        logic [2:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < 6; i++) cnt = cnt + {2'b00, v[i]};
        return cnt;
    endfunction

    // 5b/6b, abcdei, RD- column
    function automatic logic [5:0] enc6_base(input logic [4:0] x, input logic k);
        logic [5:0] r;
        case (x)
            5'd0:  r = 6'b100111;  5'd1:  r = 6'b011101;  5'd2:  r = 6'b101101;
            5'd3:  r = 6'b110001;  5'd4:  r = 6'b110101;  5'd5:  r = 6'b101001;
            5'd6:  r = 6'b011001;  5'd7:  r = 6'b111000;  5'd8:  r = 6'b111001;
            5'd9:  r = 6'b100101;  5'd10: r = 6'b010101;  5'd11: r = 6'b110100;
            5'd12: r = 6'b001101;  5'd13: r = 6'b101100;  5'd14: r = 6'b011100;
            5'd15: r = 6'b010111;  5'd16: r = 6'b011011;  5'd17: r = 6'b100011;
            5'd18: r = 6'b010011;  5'd19: r = 6'b110010;  5'd20: r = 6'b001011;
            5'd21: r = 6'b101010;  5'd22: r = 6'b011010;  5'd23: r = 6'b111010;
            5'd24: r = 6'b110011;  5'd25: r = 6'b100110;  5'd26: r = 6'b010110;
            5'd27: r = 6'b110110;  5'd28: r = k ? 6'b001111 : 6'b001110;
            5'd29: r = 6'b101110;  5'd30: r = 6'b011110;
            default: r = 6'b101011;
        endcase
        return r;
    endfunction

    // 3b/4b, fghj, RD- column; alt7 selects the A7 form of x.7
    function automatic logic [3:0] enc4_base(input logic [2:0] y, input logic alt7);
        logic [3:0] r;
        case (y)
            3'd0: r = 4'b1011;  3'd1: r = 4'b1001;  3'd2: r = 4'b0101;
            3'd3: r = 4'b1100;  3'd4: r = 4'b1101;  3'd5: r = 4'b1010;
            3'd6: r = 4'b0110;
            default: r = alt7 ? 4'b0111 : 4'b1110;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/enc_8b10b.sv
// Combinational 8b/10b encoder: {k,data,rd_in} -> {code abcdei_fghj, rd_out, k_err}.
// Illegal K requests are replaced by K28.5 and flagged.
module enc_8b10b
    import asi_pkg::*;
(
    input  logic       k,
    input  logic [7:0] data,
    input  logic       rd_in,
    output logic [9:0] code,
    output logic       rd_out,
    output logic       k_err
);

    logic [7:0] byte_v;
    logic [5:0] b6, c6;
    logic [3:0] b4, c4;
    logic [2:0] n6, n4;
    logic       rd_mid, alt7, neutral4;

    always_comb begin
        k_err  = k && !is_legal_k(data);
        byte_v = k_err ? K28_5_BYTE : data;

        b6 = enc6_base(byte_v[4:0], k);
        c6 = (rd_in && ((ones_cnt(b6) != 3'd3) || (b6 == 6'b111000))) ? ~b6 : b6;
        n6 = ones_cnt(c6);
        if (n6 > 3'd3)              rd_mid = 1'b1;
        else if (n6 < 3'd3)         rd_mid = 1'b0;
        else if (c6 == 6'b000111)   rd_mid = 1'b1;
        else if (c6 == 6'b111000)   rd_mid = 1'b0;
        else                        rd_mid = rd_in;

        alt7 = k || (!rd_mid && c6[1] && c6[0]) || (rd_mid && !c6[1] && !c6[0]);
        b4   = enc4_base(byte_v[7:5], alt7);
        neutral4 = (ones_cnt({2'b00, b4}) == 3'd2) && (b4 != 4'b1100);
        // K28 neutral 4b blocks take the opposite polarity from data blocks
        if (neutral4) c4 = (k && !rd_mid) ? ~b4 : b4;
        else          c4 = rd_mid ? ~b4 : b4;

        n4 = ones_cnt({2'b00, c4});
        if (n4 > 3'd2)              rd_out = 1'b1;
        else if (n4 < 3'd2)         rd_out = 1'b0;
        else if (c4 == 4'b0011)     rd_out = 1'b1;
        else if (c4 == 4'b1100)     rd_out = 1'b0;
        else                        rd_out = rd_mid;

        code = {c6, c4};
    end

endmodule

// File: rtl/asi_ddr_serializer.sv
// 8b/10b serializer feeding the ASI ODDR: one symbol per 5 clk, two line bits per clk.
// K28.5 idle is inserted whenever no byte is offered at a symbol boundary.
module asi_ddr_serializer
    import asi_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE = IDLE_DEFAULT,
    parameter bit         LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_is_k,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       d0,
    output logic       d1,
    output logic       sym_start,
    output logic       rd_pos,
    output logic       code_err
);

    phase_t     phase;
    logic [9:0] shreg, code, line_code;
    logic [7:0] enc_data;
    logic       enc_k, enc_rd, enc_err;

    assign s_ready = (phase == PH4);

    always_comb begin
        enc_k    = s_valid ? s_is_k : 1'b1;
        enc_data = s_valid ? s_data : IDLE_BYTE;
        line_code = code;
        if (!LSB_FIRST)
            for (int unsigned i = 0; i < 10; i++) line_code[i] = code[9 - i];
    end

    enc_8b10b u_enc (
        .k      (enc_k),
        .data   (enc_data),
        .rd_in  (rd_pos),
        .code   (code),
        .rd_out (enc_rd),
        .k_err  (enc_err)
    );

    // Load cycle drives the first pair straight from the encoder; the rest shift out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= PH4;
            shreg     <= '0;
            d0        <= 1'b0;
            d1        <= 1'b0;
            sym_start <= 1'b0;
            code_err  <= 1'b0;
            rd_pos    <= 1'b0;
        end else begin
            sym_start <= (phase == PH4);
            code_err  <= (phase == PH4) && enc_err;
            if (phase == PH4) begin
                d0     <= line_code[9];
                d1     <= line_code[8];
                shreg  <= {line_code[7:0], 2'b00};
                rd_pos <= enc_rd;
            end else begin
                d0     <= shreg[9];
                d1     <= shreg[8];
                shreg  <= {shreg[7:0], 2'b00};
            end
            case (phase)
                PH0:     phase <= PH1;
                PH1:     phase <= PH2;
                PH2:     phase <= PH3;
                PH3:     phase <= PH4;
                default: phase <= PH0;
            endcase
        end
    end

endmodule

// File: tb/tb_asi_ddr_serializer.sv
// Scoreboard bench for asi_ddr_serializer: table-driven 8b/10b reference model,
// stimulus pushes expected symbols, a negedge monitor pops and checks line bits.
module tb_asi_ddr_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_is_k = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready, d0, d1, sym_start, rd_pos, code_err;

    always #5 clk = ~clk;

    asi_ddr_serializer #(.IDLE_BYTE(8'hBC), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_is_k(s_is_k), .s_valid(s_valid),
        .s_ready(s_ready), .d0(d0), .d1(d1), .sym_start(sym_start), .rd_pos(rd_pos),
        .code_err(code_err)
    );

    typedef struct { logic [9:0] code; logic rd; logic err; } exp_t;

    int   total = 0;
    int   bad = 0;
    int   n = 0;
    logic m_rd = 1'b0;
    logic mon_en = 1'b1;
    exp_t sbq[$];

    logic [5:0] d6n [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
        6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100,
        6'b011100, 6'b010111, 6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010,
        6'b011010, 6'b111010, 6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
        6'b011110, 6'b101011};
    logic [5:0] d6p [32] = '{6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001,
        6'b011001, 6'b000111, 6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100,
        6'b011100, 6'b101000, 6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010,
        6'b011010, 6'b000101, 6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001,
        6'b100001, 6'b010100};
    logic [3:0] d4n [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    logic [3:0] d4p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
    logic [9:0] k28n [8] = '{10'b0011110100, 10'b0011111001, 10'b0011110101, 10'b0011110011,
        10'b0011110010, 10'b0011111010, 10'b0011110110, 10'b0011111000};
    logic [9:0] k28p [8] = '{10'b1100001011, 10'b1100000110, 10'b1100001010, 10'b1100001100,
        10'b1100001101, 10'b1100000101, 10'b1100001001, 10'b1100000111};
    logic [7:0] klist [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
        8'hF7, 8'hFB, 8'hFD, 8'hFE};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // RD after a sub-block: sign of disparity, with 000111/0011 -> RD+ and 111000/1100 -> RD-
    function automatic logic rd_after(input logic [5:0] v, input int width, input logic rd);
        int ones = 0;
        for (int i = 0; i < width; i++) ones += v[i];
        if (2 * ones > width) return 1'b1;
        if (2 * ones < width) return 1'b0;
        if (width == 6 && v == 6'b000111) return 1'b1;
        if (width == 6 && v == 6'b111000) return 1'b0;
        if (width == 4 && v[3:0] == 4'b0011) return 1'b1;
        if (width == 4 && v[3:0] == 4'b1100) return 1'b0;
        return rd;
    endfunction

    function automatic exp_t model(input logic v, input logic k, input logic [7:0] b, input logic rd);
        exp_t e;
        logic kk, r, a7;
        logic [7:0] x;
        logic [5:0] six;
        logic [3:0] four;
        kk = v ? k : 1'b1;
        x  = v ? b : 8'hBC;
        e.err = kk && !((x[4:0] == 5'd28) || x inside {8'hF7, 8'hFB, 8'hFD, 8'hFE});
        if (e.err) x = 8'hBC;
        if (kk && x[4:0] == 5'd28) begin
            e.code = rd ? k28p[x[7:5]] : k28n[x[7:5]];
        end else begin
            six = rd ? d6p[x[4:0]] : d6n[x[4:0]];
            r   = rd_after(six, 6, rd);
            a7  = kk || (!r && x[4:0] inside {5'd17, 5'd18, 5'd20}) ||
                  (r && x[4:0] inside {5'd11, 5'd13, 5'd14});
            if (x[7:5] == 3'd7 && a7) four = r ? 4'b1000 : 4'b0111;
            else                      four = r ? d4p[x[7:5]] : d4n[x[7:5]];
            e.code = {six, four};
        end
        e.rd = rd_after({2'b00, e.code[3:0]}, 4, rd_after(e.code[9:4], 6, rd));
        return e;
    endfunction

    // One symbol slot: garbage on non-ready cycles, the offered byte at the boundary
    task automatic send(input logic v, input logic k, input logic [7:0] b);
        logic rdy;
        exp_t e;
        do begin
            @(negedge clk); #1;
            rdy = (n % 5 == 0);
            if (rdy) begin
                s_valid = v; s_is_k = k; s_data = b;
            end else begin
                s_valid = 1'($urandom); s_is_k = 1'($urandom); s_data = 8'($urandom);
            end
            chk("s_ready", {31'd0, s_ready}, {31'd0, rdy});
            if (rdy) begin
                e = model(v, k, b, m_rd);
                m_rd = e.rd;
                sbq.push_back(e);
            end
            n++;
        end while (!rdy);
    endtask

    // Monitor: every queued symbol must start at the next negedge and shift out over 5 clk
    initial begin
        int   idx = 5;
        logic cur_rd = 1'b0;
        exp_t cur;
        forever begin
            @(negedge clk);
            if (!mon_en) continue;
            if (!rst_n) begin
                idx = 5; cur_rd = 1'b0;
                chk("reset_outputs", {27'd0, d0, d1, sym_start, code_err, rd_pos}, 32'd0);
                continue;
            end
            chk("sym_start", {31'd0, sym_start}, {31'd0, (sbq.size() > 0)});
            if (sbq.size() > 0) begin
                chk("sym_boundary", idx, 5);
                cur = sbq.pop_front();
                idx = 0;
                cur_rd = cur.rd;
            end
            if (idx < 5) begin
                chk($sformatf("pair%0d", idx), {30'd0, d0, d1},
                    {30'd0, cur.code[9 - 2 * idx], cur.code[8 - 2 * idx]});
                chk("code_err", {31'd0, code_err}, {31'd0, (idx == 0) ? cur.err : 1'b0});
                idx++;
            end else begin
                chk("idle_pair", {30'd0, d0, d1}, 32'd0);
                chk("code_err_idle", {31'd0, code_err}, 32'd0);
            end
            chk("rd_pos", {31'd0, rd_pos}, {31'd0, cur_rd});
        end
    end

    initial begin
        logic k;
        logic [7:0] b;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1; n = 0;

        // idles from RD-, byte stream, D21.5, illegal K, D.x.7 forms, legal K set
        repeat (3) send(1'b0, 1'b0, 8'h00);
        send(1'b1, 1'b0, 8'h00); send(1'b1, 1'b0, 8'h01); send(1'b1, 1'b0, 8'h02);
        send(1'b1, 1'b0, 8'hB5); send(1'b1, 1'b0, 8'hB5);
        send(1'b1, 1'b1, 8'h00);
        send(1'b1, 1'b0, 8'hF1); send(1'b1, 1'b0, 8'hF1);
        send(1'b0, 1'b0, 8'h00); send(1'b1, 1'b0, 8'hEB); send(1'b1, 1'b0, 8'hEB);
        send(1'b1, 1'b0, 8'h67); send(1'b1, 1'b0, 8'hE7); send(1'b1, 1'b0, 8'hE7);
        for (int i = 0; i < 12; i++) send(1'b1, 1'b1, klist[i]);

        for (int i = 0; i < 150; i++) begin
            k = ($urandom_range(0, 4) == 0);
            b = 8'($urandom);
            if (k && $urandom_range(0, 1) == 1) b = klist[$urandom_range(0, 11)];
            send(($urandom_range(0, 3) != 0), k, b);
        end

        // abort mid-symbol while pair (e,i) is on the line
        send(1'b1, 1'b0, 8'h3A);
        repeat (2) begin
            @(negedge clk); #1;
            chk("s_ready_mid", {31'd0, s_ready}, {31'd0, (n % 5 == 0)});
            n++;
        end
        @(negedge clk); #1;
        rst_n = 1'b0;
        sbq.delete();
        m_rd = 1'b0;
        #1 chk("reset_async_d", {29'd0, d0, d1, sym_start}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; n = 0;

        send(1'b0, 1'b0, 8'h00); send(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++) send(1'b1, 1'($urandom_range(0, 3) == 0), 8'($urandom));

        repeat (5) @(negedge clk);
        #2 mon_en = 1'b0;
        chk("queue_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
